// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the MMIO window tag default, the MMIO register offsets (addr[3:2]),
// the FSM state encoding and a byte-lane merge helper used by MMIO writes.
package data_mem_responder_pkg;

    localparam logic [3:0] MMIO_TAG_DEF = 4'h1;

    localparam logic [1:0] OFS_LED     = 2'd0;
    localparam logic [1:0] OFS_COUNT   = 2'd1;
    localparam logic [1:0] OFS_SCRATCH = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // Replace the bytes of old_word whose lane enable is set.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++)
            if (sel[k]) res[8*k +: 8] = new_word[8*k +: 8];
        return res;
    endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// dmem_ram: single-port synchronous word RAM, 4 byte-lane write enables,
// registered read port.
// Ports: clk, rst (async active-low, clears only the read register),
//        rd_en (capture mem[addr] into rdata), be (per-lane write enables),
//        addr (word index), wdata, rdata (registered, holds between reads).
module dmem_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rdata <= '0;
        else if (rd_en) rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the CPU data-memory port.
// Serves RAM (dmem_ram) and a small MMIO window (LED, free-running COUNT,
// SCRATCH). Loads take one stall cycle; stores commit with no stall.
// Ports: clk, rst (async active-low), ce_i/we_i/addr_i/data_i/sel_i request,
//        data_o registered read data, stall_req_o (request cycle of a load),
//        led_o LED register.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int         ADDR_WIDTH = 10,
    parameter logic [3:0] MMIO_TAG   = MMIO_TAG_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] data_o,
    output logic        stall_req_o,
    output logic [15:0] led_o
);

    state_t      state, next_state;
    logic        is_mmio, wr, rd_fire;
    logic [1:0]  reg_ofs;
    logic [31:0] count, scratch, mmio_rdata, mmio_q, ram_q, led_next;
    logic        src_mmio;
    logic        unused_addr;

    assign is_mmio = (addr_i[31:28] == MMIO_TAG);
    assign reg_ofs = addr_i[3:2];
    assign wr      = ce_i & we_i;
    // Gated by rst so the stall drops while reset is held, even with a load
    // still presented.
    assign rd_fire = rst & (state == IDLE) & ce_i & ~we_i;
    assign stall_req_o = rd_fire;
    assign unused_addr = ^addr_i;

    dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .rd_en (rd_fire & ~is_mmio),
        .be    ((wr & ~is_mmio) ? sel_i : 4'b0000),
        .addr  (addr_i[ADDR_WIDTH+1:2]),
        .wdata (data_i),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (rd_fire) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mmio_rdata = '0;
        case (reg_ofs)
            OFS_LED:     mmio_rdata = {16'h0000, led_o};
            OFS_COUNT:   mmio_rdata = count;
            OFS_SCRATCH: mmio_rdata = scratch;
            default:     mmio_rdata = '0;
        endcase
    end

    // LED only owns byte lanes 0-1.
    assign led_next = lane_merge({16'h0000, led_o}, data_i, sel_i & 4'b0011);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            scratch  <= '0;
            led_o    <= '0;
            mmio_q   <= '0;
            src_mmio <= 1'b0;
        end else begin
            count <= count + 32'd1;
            if (wr && is_mmio) begin
                if (reg_ofs == OFS_LED)     led_o   <= led_next[15:0];
                if (reg_ofs == OFS_SCRATCH) scratch <= lane_merge(scratch, data_i, sel_i);
            end
            if (rd_fire) begin
                src_mmio <= is_mmio;
                if (is_mmio) mmio_q <= mmio_rdata;
            end
        end
    end

    // Both sources are registers that only move on a capture, so data_o holds.
    assign data_o = src_mmio ? mmio_q : ram_q;

endmodule
